data_mem: RTL and testbench

- Synchronous data memory for the MIPS-style datapath.
- Sits between the ALU address output and the write-back select mux; its `rdata` drives that mux's memory-data input.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Provides a registered one-cycle load latency with a valid pulse, a busy flag, and misalignment detection.

---
 rtl/data_mem.sv | 195 +++++++++++++++++++
 tb/tb_data_mem.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem : synchronous data memory for the MIPS-style datapath.
//
// Byte / halfword / word loads and stores with sign or zero extension on
// loads. Stores complete in the request cycle. Loads take one extra cycle,
// spent in the LOAD state, and return the result registered with a
// one-cycle rvalid pulse. Misaligned requests are rejected and flagged with
// a one-cycle misalign pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high (array contents kept)
//   memread      load request, sampled in IDLE
//   memwrite     store request, sampled in IDLE, wins over memread
//   size[1:0]    00 byte, 01 halfword, 10/11 word
//   unsigned_ld  1 = zero-extend, 0 = sign-extend (ignored for word)
//   addr[31:0]   byte address, upper bits ignored (wraps at DEPTH*4)
//   wdata[31:0]  store data, right-aligned
//   rdata[31:0]  registered load result, held between loads
//   rvalid       one-cycle pulse when rdata is updated
//   busy         high while a load is in flight (requests ignored)
//   misalign     one-cycle pulse after a rejected misaligned request
// ---------------------------------------------------------------------------
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        misalign
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    // Byte access is always aligned; halfword needs addr[0]=0; word (and the
    // reserved size code, treated as word) needs addr[1:0]=00.
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] ln);
        logic ok;
        case (sz)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (ln[0] == 1'b0);
            default: ok = (ln == 2'b00);
        endcase
        return ok;
    endfunction

    // Select the addressed lane(s) of a stored word and extend to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  ln,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [31:0]       mem_q [DEPTH];

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              busy_q;
    logic              misalign_q;

    logic [ADDR_W-1:0] widx_s;
    logic [1:0]        lane_s;
    logic              aligned_s;
    logic              we_s;
    logic [3:0]        be_s;
    logic [31:0]       wword_s;
    logic [31:0]       rdata_d;
    logic              unused_addr_s;

    assign widx_s        = addr[ADDR_W+1:2];
    assign lane_s        = addr[1:0];
    assign aligned_s     = is_aligned(size, lane_s);
    assign rdata_d       = extend_load(mem_q[idx_q], size_q, lane_q, uns_q);
    assign unused_addr_s = ^addr[31:ADDR_W+2];

    // Store enable, byte-lane mask and lane-replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wword_s = wdata;
        if (!rst && (state_q == IDLE) && memwrite && aligned_s) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
        case (size)
            2'b00: begin
                be_s    = 4'b0001 << lane_s;
                wword_s = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                wword_s = {2{wdata[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wword_s = wdata;
            end
        endcase
    end

    // Memory array: lane-masked writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered outputs; rvalid/misalign default low so
    // they only ever last a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memwrite) begin
                        // The store itself happens in the array block.
                        misalign_q <= ~aligned_s;
                    end else if (memread) begin
                        if (aligned_s) begin
                            idx_q   <= widx_s;
                            lane_q  <= lane_s;
                            size_q  <= size;
                            uns_q   <= unsigned_ld;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            misalign_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign busy     = busy_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
        .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .misalign(misalign)
    );

    typedef struct {
        logic        is_wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_mis;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    // One request, then check both following cycles.
    task automatic run_op(input vec_t v, input int n);
        string tag;
        tag         = $sformatf("vec%0d", n);
        memwrite    = v.is_wr;
        memread     = ~v.is_wr;
        size        = v.sz;
        unsigned_ld = v.uns;
        addr        = v.a;
        wdata       = v.wd;
        @(posedge clk); #1;
        idle_inputs();
        chk({tag, "_misalign"}, {31'd0, misalign}, {31'd0, v.exp_mis});
        chk({tag, "_rvalid0"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (~v.is_wr & ~v.exp_mis)});
        @(posedge clk); #1;
        chk({tag, "_misalign_end"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_rvalid1"}, {31'd0, rvalid}, {31'd0, (~v.is_wr & ~v.exp_mis)});
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
    endtask

    initial begin
        vec_t t;
        //          wr    size   uns   addr          wdata          mis   rdata
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        1'b0, 32'hFFFFFFDE};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        1'b0, 32'h000000DE};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000005A, 1'b0, 32'h000000DE};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD5AEF};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        1'b0, 32'hFFFFDEAD};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h00001234, 1'b0, 32'hFFFFDEAD};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD1234};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        1'b1, 32'hDEAD1234};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000FFFF, 1'b1, 32'hDEAD1234};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD1234};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        1'b0, 32'h00001234};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1'b0, 32'h00000012};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,        1'b0, 32'hFFFFFFAD};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1'b0, 32'h0000DEAD};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFEF00D, 1'b0, 32'h0000DEAD};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[18] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD1234};
        vecs[19] = '{1'b0, 2'b11, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 32'hDEAD1234};
        vecs[20] = '{1'b1, 2'b00, 1'b0, 32'h0000_03FF, 32'hFFFFFF80, 1'b0, 32'hDEAD1234};
        vecs[21] = '{1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,        1'b0, 32'h00000080};
        vecs[22] = '{1'b0, 2'b00, 1'b0, 32'h0000_03FF, 32'h0,        1'b0, 32'hFFFFFF80};

        rst = 1'b1; memread = 1'b0; memwrite = 1'b0; size = 2'b10;
        unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], i);
        end

        // memwrite wins over memread: store happens, no load.
        memread = 1'b1; memwrite = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h11111111;
        @(posedge clk); #1;
        idle_inputs();
        chk("prio_busy", {31'd0, busy}, 32'd0);
        chk("prio_rvalid0", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("prio_rvalid1", {31'd0, rvalid}, 32'd0);
        chk("prio_rdata", rdata, 32'hFFFFFF80);
        t = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111};
        run_op(t, 100);

        // Store issued while busy is ignored.
        memread = 1'b1; size = 2'b10; addr = 32'h10;
        @(posedge clk); #1;
        chk("busyign_busy", {31'd0, busy}, 32'd1);
        memread = 1'b0; memwrite = 1'b1; addr = 32'h10; wdata = 32'h99999999;
        @(posedge clk); #1;
        idle_inputs();
        chk("busyign_rvalid", {31'd0, rvalid}, 32'd1);
        chk("busyign_rdata", rdata, 32'hDEAD1234);
        chk("busyign_misalign", {31'd0, misalign}, 32'd0);
        t = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD1234};
        run_op(t, 101);

        // Back-to-back: second load accepted in the rvalid cycle.
        memread = 1'b1; size = 2'b10; addr = 32'h20;
        @(posedge clk); #1;
        memread = 1'b0;
        @(posedge clk); #1;
        chk("b2b_rvalid_a", {31'd0, rvalid}, 32'd1);
        chk("b2b_rdata_a", rdata, 32'h11111111);
        memread = 1'b1; addr = 32'h0;
        @(posedge clk); #1;
        memread = 1'b0;
        chk("b2b_busy_b", {31'd0, busy}, 32'd1);
        chk("b2b_rvalid_gap", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_rvalid_b", {31'd0, rvalid}, 32'd1);
        chk("b2b_rdata_b", rdata, 32'hCAFEF00D);

        // Reset in the LOAD cycle abandons the load.
        memread = 1'b1; size = 2'b10; addr = 32'h10;
        @(posedge clk); #1;
        memread = 1'b0;
        chk("rstld_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstld_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rstld_rdata", rdata, 32'h0);
        chk("rstld_busy0", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("rstld_rvalid_after", {31'd0, rvalid}, 32'd0);
        chk("rstld_rdata_after", rdata, 32'h0);
        t = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D};
        run_op(t, 102);
        t = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD1234};
        run_op(t, 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
